// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scanner: walks a one-hot column drive, debounces press and release,
// and hands accepted keys to a consumer through a valid/ack handshake with overrun flag.
module keypad_scan_ctrl #(
  parameter int SCAN_DIV     = 2,
  parameter int DEBOUNCE_CYC = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ack,
  output logic       overrun
);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, RELEASE} state_e;

  localparam logic [7:0] DWELL_LAST = 8'(SCAN_DIV - 1);
  localparam logic [7:0] STAB_LAST  = 8'(DEBOUNCE_CYC - 1);

  state_e     state_q, state_d;
  logic [3:0] col_q, col_d;
  logic [7:0] dwell_q, dwell_d;
  logic [7:0] stab_q, stab_d;
  logic [3:0] cap_row_q, cap_row_d;
  logic [3:0] key_code_q, key_code_d;
  logic       key_valid_q, key_valid_d;
  logic       overrun_q, overrun_d;

  logic [3:0] col_ring;
  logic       accept;
  logic       single_row;
  logic       new_key;
  logic       overrun_set;
  logic [1:0] col_idx;
  logic [1:0] row_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= SCAN;
      col_q       <= 4'b1000;
      dwell_q     <= 8'd0;
      stab_q      <= 8'd0;
      cap_row_q   <= 4'd0;
      key_code_q  <= 4'd0;
      key_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      dwell_q     <= dwell_d;
      stab_q      <= stab_d;
      cap_row_q   <= cap_row_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    dwell_d   = dwell_q;
    stab_d    = stab_q;
    cap_row_d = cap_row_q;
    accept    = 1'b0;
    col_ring  = {col_q[0], col_q[3:1]};

    case (state_q)
      SCAN: begin
        if (dwell_q == DWELL_LAST) begin
          dwell_d = 8'd0;
          if (row != 4'd0) begin
            cap_row_d = row;
            stab_d    = 8'd0;
            state_d   = DEBOUNCE;
          end else begin
            col_d = col_ring;
          end
        end else begin
          dwell_d = dwell_q + 8'd1;
        end
      end
      DEBOUNCE: begin
        if (row == cap_row_q) begin
          if (stab_q == STAB_LAST) begin
            accept  = 1'b1;
            stab_d  = 8'd0;
            state_d = RELEASE;
          end else begin
            stab_d = stab_q + 8'd1;
          end
        end else begin
          stab_d  = 8'd0;
          col_d   = col_ring;
          dwell_d = 8'd0;
          state_d = SCAN;
        end
      end
      RELEASE: begin
        if (row == 4'd0) begin
          if (stab_q == STAB_LAST) begin
            stab_d  = 8'd0;
            col_d   = col_ring;
            dwell_d = 8'd0;
            state_d = SCAN;
          end else begin
            stab_d = stab_q + 8'd1;
          end
        end else begin
          stab_d = 8'd0;
        end
      end
      default: state_d = SCAN;
    endcase
  end

  // Multi-bit captures (ghosting) are accepted for release tracking but never yield a key.
  always_comb begin
    col_idx = 2'd0;
    case (col_q)
      4'b1000: col_idx = 2'd0;
      4'b0100: col_idx = 2'd1;
      4'b0010: col_idx = 2'd2;
      4'b0001: col_idx = 2'd3;
      default: col_idx = 2'd0;
    endcase
    row_idx = 2'd0;
    case (cap_row_q)
      4'b0001: row_idx = 2'd0;
      4'b0010: row_idx = 2'd1;
      4'b0100: row_idx = 2'd2;
      4'b1000: row_idx = 2'd3;
      default: row_idx = 2'd0;
    endcase
    single_row = (cap_row_q != 4'd0) && ((cap_row_q & (cap_row_q - 4'd1)) == 4'd0);
    new_key    = accept && single_row;
  end

  always_comb begin
    key_code_d  = key_code_q;
    key_valid_d = key_valid_q;
    overrun_set = 1'b0;
    if (new_key) begin
      if (!key_valid_q || key_ack) begin
        key_code_d  = {col_idx, row_idx};
        key_valid_d = 1'b1;
      end else begin
        overrun_set = 1'b1;
      end
    end else if (key_ack) begin
      key_valid_d = 1'b0;
    end
    overrun_d = overrun_set | (overrun_q & ~key_ack);
  end

  assign col       = col_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl (SCAN_DIV=2, DEBOUNCE_CYC=4); expected key codes
// are queued when a press is driven and popped at the edge where the key must appear.
module tb_keypad_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ack;
  logic       overrun;

  int         tests = 0;
  int         failures = 0;
  logic [3:0] expQ[$];

  keypad_scan_ctrl #(.SCAN_DIV(2), .DEBOUNCE_CYC(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .row      (row),
    .col      (col),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_ack  (key_ack),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [3:0] observed, input logic [3:0] expected);
    tests++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  function automatic logic [3:0] expCode(input logic [3:0] c, input logic [3:0] r);
    int ci;
    int ri;
    ci = 0;
    ri = 0;
    case (c)
      4'b1000: ci = 0;
      4'b0100: ci = 1;
      4'b0010: ci = 2;
      4'b0001: ci = 3;
      default: ci = 0;
    endcase
    case (r)
      4'b0001: ri = 0;
      4'b0010: ri = 1;
      4'b0100: ri = 2;
      4'b1000: ri = 3;
      default: ri = 0;
    endcase
    return 4'(ci * 4 + ri);
  endfunction

  // Leaves the bench on the first cycle of a fresh dwell on column c.
  task automatic syncToCol(input logic [3:0] c);
    logic left;
    logic found;
    left  = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (col != c) begin
        left = 1'b1;
        break;
      end
      tick();
    end
    if (left) begin
      for (int k = 0; k < 20; k++) begin
        if (col == c) begin
          found = 1'b1;
          break;
        end
        tick();
      end
    end
    checkOutput("sync_col", {3'b000, found}, 4'd1);
  endtask

  // Full press on column c with row pattern r: capture, 4 stable matches, release.
  task automatic applyStimulus(input logic [3:0] c, input logic [3:0] r,
                               input logic ackAtAccept, input logic expectKey);
    logic [3:0] prevCode;
    logic       prevValid;
    logic [3:0] nextCol;
    logic [3:0] want;
    nextCol = {c[0], c[3:1]};
    syncToCol(c);
    prevCode  = key_code;
    prevValid = key_valid;
    row = r;
    if (expectKey) expQ.push_back(expCode(c, r));
    tick();
    tick();
    tick();
    tick();
    tick();
    checkOutput("debounce_col_frozen", col, c);
    checkOutput("pre_accept_code", key_code, prevCode);
    checkOutput("pre_accept_valid", {3'b000, key_valid}, {3'b000, prevValid});
    key_ack = ackAtAccept;
    tick();
    key_ack = 1'b0;
    if (expectKey) begin
      if (expQ.size() == 0) begin
        checkOutput("scoreboard_empty", 4'd1, 4'd0);
      end else begin
        want = expQ.pop_front();
        checkOutput("accepted_code", key_code, want);
        checkOutput("accepted_valid", {3'b000, key_valid}, 4'd1);
      end
    end
    tick();
    tick();
    checkOutput("held_col_frozen", col, c);
    row = 4'd0;
    tick();
    tick();
    tick();
    checkOutput("release_col_frozen", col, c);
    tick();
    checkOutput("release_resume_col", col, nextCol);
  endtask

  initial begin
    logic [3:0] ring [4];
    ring[0] = 4'b1000;
    ring[1] = 4'b0100;
    ring[2] = 4'b0010;
    ring[3] = 4'b0001;

    rst_n   = 1'b0;
    row     = 4'd0;
    key_ack = 1'b0;
    tick();
    tick();
    checkOutput("reset_col", col, 4'b1000);
    checkOutput("reset_code", key_code, 4'd0);
    checkOutput("reset_valid", {3'b000, key_valid}, 4'd0);
    checkOutput("reset_overrun", {3'b000, overrun}, 4'd0);
    rst_n = 1'b1;

    // Idle scan: two samples per column in ring order.
    for (int i = 0; i < 16; i++) begin
      checkOutput("idle_col", col, ring[(i / 2) % 4]);
      tick();
    end
    checkOutput("idle_valid", {3'b000, key_valid}, 4'd0);

    // Clean press on column 1, row 2 -> code 6, then acknowledge.
    applyStimulus(4'b0100, 4'b0100, 1'b0, 1'b1);
    checkOutput("press_valid_kept", {3'b000, key_valid}, 4'd1);
    checkOutput("press_no_repeat", key_code, 4'd6);
    key_ack = 1'b1;
    tick();
    key_ack = 1'b0;
    checkOutput("ack_clears_valid", {3'b000, key_valid}, 4'd0);
    checkOutput("ack_overrun", {3'b000, overrun}, 4'd0);
    key_ack = 1'b1;
    tick();
    key_ack = 1'b0;
    checkOutput("idle_ack_valid", {3'b000, key_valid}, 4'd0);
    checkOutput("idle_ack_code", key_code, 4'd6);

    // Bounce: row seen for two cycles only.
    syncToCol(4'b1000);
    row = 4'b0001;
    tick();
    tick();
    row = 4'd0;
    tick();
    checkOutput("bounce_resume_col", col, 4'b0100);
    for (int i = 0; i < 6; i++) tick();
    checkOutput("bounce_valid", {3'b000, key_valid}, 4'd0);

    // Ghost: two rows on column 3, no key but release still enforced.
    applyStimulus(4'b0001, 4'b0011, 1'b0, 1'b0);
    checkOutput("ghost_valid", {3'b000, key_valid}, 4'd0);
    checkOutput("ghost_code", key_code, 4'd6);

    // Overrun: second key dropped while first unacknowledged.
    applyStimulus(4'b0010, 4'b0001, 1'b0, 1'b1);
    applyStimulus(4'b0100, 4'b1000, 1'b0, 1'b0);
    checkOutput("overrun_code_held", key_code, 4'd8);
    checkOutput("overrun_valid", {3'b000, key_valid}, 4'd1);
    checkOutput("overrun_set", {3'b000, overrun}, 4'd1);
    key_ack = 1'b1;
    tick();
    key_ack = 1'b0;
    checkOutput("overrun_ack_valid", {3'b000, key_valid}, 4'd0);
    checkOutput("overrun_ack_clear", {3'b000, overrun}, 4'd0);

    // Ack coincident with a new acceptance while overrun is pending.
    applyStimulus(4'b0001, 4'b0010, 1'b0, 1'b1);
    applyStimulus(4'b0100, 4'b0001, 1'b0, 1'b0);
    checkOutput("drop2_code_held", key_code, 4'd13);
    checkOutput("drop2_overrun", {3'b000, overrun}, 4'd1);
    applyStimulus(4'b1000, 4'b0100, 1'b1, 1'b1);
    checkOutput("coincident_valid", {3'b000, key_valid}, 4'd1);
    checkOutput("coincident_overrun", {3'b000, overrun}, 4'd0);
    key_ack = 1'b1;
    tick();
    key_ack = 1'b0;
    checkOutput("final_ack_valid", {3'b000, key_valid}, 4'd0);

    // Reset in the middle of the stability count.
    syncToCol(4'b0100);
    row = 4'b0010;
    tick();
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_col", col, 4'b1000);
    checkOutput("midrst_code", key_code, 4'd0);
    checkOutput("midrst_valid", {3'b000, key_valid}, 4'd0);
    checkOutput("midrst_overrun", {3'b000, overrun}, 4'd0);
    row = 4'd0;
    tick();
    rst_n = 1'b1;
    checkOutput("post_rst_col0", col, 4'b1000);
    tick();
    checkOutput("post_rst_col1", col, 4'b1000);
    tick();
    checkOutput("post_rst_col2", col, 4'b0100);
    checkOutput("post_rst_valid", {3'b000, key_valid}, 4'd0);
    applyStimulus(4'b0100, 4'b0010, 1'b0, 1'b1);
    checkOutput("post_rst_fresh_code", key_code, 4'd5);
    checkOutput("scoreboard_drained", 4'(expQ.size()), 4'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/keypad_scan_ctrl.md
KEYPAD_SCAN_CTRL -- requirements
Module: keypad_scan_ctrl

Interface
REQ-001 Parameter SCAN_DIV, default 2: clock cycles each column stays driven while scanning; legal range 1..255.
REQ-002 Parameter DEBOUNCE_CYC, default 4: consecutive stable samples required for press and for release; legal range 1..255.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 row  input  4  keypad row lines, active-high, sampled directly on clk; synchronization is external to this block.
REQ-006 col  output  4  one-hot column drive, registered.
REQ-007 key_code  output  4  code of last accepted key, registered.
REQ-008 key_valid  output  1  key_code holds an unacknowledged key.
REQ-009 key_ack  input  1  consumer acknowledge, sampled on clk.
REQ-010 overrun  output  1  sticky flag: an accepted key was dropped.

Function
REQ-011 Column index mapping SHALL be col=1000->0, 0100->1, 0010->2, 0001->3; row index SHALL be the bit position in row (row[0]->0).
REQ-012 key_code SHALL equal col_idx*4 + row_idx, 4-bit unsigned, no overflow possible.
REQ-013 FSM SHALL have three states: SCAN, DEBOUNCE, RELEASE.
REQ-014 SCAN: col SHALL advance in ring order 1000->0100->0010->0001->1000 after each SCAN_DIV cycles; 0001 wraps to 1000.
REQ-015 SCAN: on the last dwell cycle of a column, if row!=0, the block SHALL capture col_idx and row, hold col, and enter DEBOUNCE instead of advancing.
REQ-016 DEBOUNCE: col frozen; each cycle row equal to the captured value increments a stability counter; any mismatch SHALL return to SCAN, advancing col to the next column with a fresh dwell.
REQ-017 DEBOUNCE: on the DEBOUNCE_CYC-th consecutive match, the key is accepted and the FSM enters RELEASE in the same cycle.
REQ-018 Accepted capture with exactly one row bit set SHALL produce a key; with two or more bits set (ghost/multi-press) no key SHALL be produced, and RELEASE SHALL still be entered.
REQ-019 Key produced with key_valid=0: key_code and key_valid=1 SHALL update on the accepting edge (latency DEBOUNCE_CYC cycles after the capture edge).
REQ-020 Key produced with key_valid=1 and key_ack=0: key SHALL be dropped, key_code unchanged, overrun set to 1.
REQ-021 Key produced in the same cycle key_ack=1 with key_valid=1: new key_code loaded, key_valid stays 1, overrun not set.
REQ-022 key_ack=1 with key_valid=1 and no new key SHALL clear key_valid on that edge; key_ack with key_valid=0 SHALL have no effect.
REQ-023 overrun SHALL clear on any edge where key_ack=1, unless the same edge sets it (set wins).
REQ-024 RELEASE: col frozen; FSM SHALL return to SCAN, advancing col to the next column, after DEBOUNCE_CYC consecutive cycles with row==0; any nonzero row resets the count.
REQ-025 A key held indefinitely SHALL produce exactly one key_valid pulse-sequence; no auto-repeat.
REQ-026 col SHALL always be exactly one-hot, including the cycle after reset.

Reset
REQ-027 While rst_n=0: state=SCAN, col=1000, key_code=0, key_valid=0, overrun=0, dwell and stability counters=0.
REQ-028 Reset asserted mid-DEBOUNCE or mid-RELEASE SHALL abandon the key without producing key_valid; scanning restarts at col=1000 with a full dwell after release of rst_n.

Verification (SCAN_DIV=2, DEBOUNCE_CYC=4)
REQ-029 Idle: release reset, row=0 for 16 cycles -> col sequence 1000,1000,0100,0100,0010,0010,0001,0001, repeating; key_valid=0.
REQ-030 Press: row=0100 only while col=0100, held -> key_valid=1 with key_code=6, four cycles after capture; col frozen at 0100 until row=0 for 4 cycles, then 0010.
REQ-031 Bounce: row=0001 on col=1000 for 2 cycles then 0 -> no key_valid, scan resumes at 0100.
REQ-032 Ghost: row=0011 stable on col=0001 -> no key_valid, RELEASE entered, scan resumes after row=0 for 4 cycles.
REQ-033 Overrun/ack: two keys accepted without ack -> key_code holds first, overrun=1; key_ack=1 one cycle -> key_valid=0, overrun=0; ack coincident with a third acceptance -> new key_code, key_valid=1, overrun=0.
REQ-034 Reset mid-DEBOUNCE: rst_n=0 during stability count -> all outputs reset values per REQ-027, no key_valid after rst_n=1 until a fresh full press.
